// File: rtl/mc_cpu_pkg.sv
// Shared types and encodings for the multi-cycle accumulator CPU control path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mc_cpu_pkg;

   typedef logic [2:0] opcode_t;
   typedef logic [1:0] alu_op_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH1,
      S_FETCH2,
      S_DECODE,
      S_MEM_RD,
      S_EXEC_ALU,
      S_EXEC_NOT,
      S_MEM_WR,
      S_JUMP
   } state_t;

   localparam opcode_t OP_ADD = 3'b000;
   localparam opcode_t OP_SUB = 3'b001;
   localparam opcode_t OP_AND = 3'b010;
   localparam opcode_t OP_NOT = 3'b011;
   localparam opcode_t OP_LDA = 3'b100;
   localparam opcode_t OP_STA = 3'b101;
   localparam opcode_t OP_JMP = 3'b110;
   localparam opcode_t OP_JZ  = 3'b111;

   localparam alu_op_t ALU_ADD = 2'b00;
   localparam alu_op_t ALU_SUB = 2'b01;
   localparam alu_op_t ALU_AND = 2'b10;
   localparam alu_op_t ALU_NOT = 2'b11;

   localparam logic PC_SRC_INC  = 1'b0;  // PC + 1
   localparam logic PC_SRC_IR   = 1'b1;  // IR[12:0]
   localparam logic ACC_SRC_ALU = 1'b0;
   localparam logic ACC_SRC_MEM = 1'b1;
   localparam logic ADDR_SRC_PC = 1'b0;
   localparam logic ADDR_SRC_IR = 1'b1;

   // States that hold a memory request open until mem_ready.
   function automatic logic is_mem_req(input state_t s);
      return (s == S_FETCH1) || (s == S_FETCH2) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control bundle between mc_controller (master) and the datapath/memory (slave).
// Latency: n/a (wiring only). Backpressure: memory stalls the master via mem_ready.
// Ports: opcode/acc_zero/mem_ready into the controller; strobes and selects out.
// Optional mem_fault exists only when MC_CTRL_MEM_TIMEOUT_EN is defined.
interface mc_controller_if;
   import mc_cpu_pkg::*;

   opcode_t opcode;
   logic    acc_zero;
   logic    mem_ready;
   logic    mem_read;
   logic    mem_write;
   logic    addr_src;
   logic    ir1_write;
   logic    ir2_write;
   logic    mdr_write;
   logic    pc_write;
   logic    pc_src;
   logic    acc_write;
   logic    acc_src;
   alu_op_t alu_op;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
   logic    mem_fault;
`endif

   modport master (
      input  opcode, acc_zero, mem_ready,
      output mem_read, mem_write, addr_src, ir1_write, ir2_write, mdr_write,
             pc_write, pc_src, acc_write, acc_src, alu_op
`ifdef MC_CTRL_MEM_TIMEOUT_EN
      , output mem_fault
`endif
   );

   modport slave (
      output opcode, acc_zero, mem_ready,
      input  mem_read, mem_write, addr_src, ir1_write, ir2_write, mdr_write,
             pc_write, pc_src, acc_write, acc_src, alu_op
`ifdef MC_CTRL_MEM_TIMEOUT_EN
      , input mem_fault
`endif
   );

endinterface

// File: rtl/mc_ctrl_timeout.sv
// Memory wait counter with a sticky fault flag.
// Latency: timed_out is combinational from the count; fault rises the cycle after.
// Backpressure: none; it only observes stall cycles.
// Ports: clk, rst, stall (request pending, not ready), clear (state change or
// timeout), timed_out (count hit TIMEOUT_CYCLES), fault (sticky until rst).
module mc_ctrl_timeout #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic stall,
   input  logic clear,
   output logic timed_out,
   output logic fault
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;

   assign timed_out = (cnt == CW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         fault <= 1'b0;
      end else begin
         if (clear)
            cnt <= '0;
         else if (stall)
            cnt <= cnt + 1'b1;
         if (timed_out)
            fault <= 1'b1;
      end
   end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the accumulator CPU: fetch, decode, operand, writeback.
// Latency: zero-wait 3..5 cycles per instruction; strobes are Mealy on mem_ready only.
// Backpressure: memory requests are held with stable addr_src until mem_ready.
// Ports: clk, rst (sync, active-high) and ctrl (mc_controller_if.master).
// Optional memory-wait timeout with sticky mem_fault: define MC_CTRL_MEM_TIMEOUT_EN.
module mc_controller
`ifdef MC_CTRL_MEM_TIMEOUT_EN
   #(parameter int TIMEOUT_CYCLES = 16)
`endif
(
   input  logic            clk,
   input  logic            rst,
   mc_controller_if.master ctrl
);
   import mc_cpu_pkg::*;

   state_t  state, state_nx;
   opcode_t op_q;       // opcode captured in DECODE, used by later states
   logic    timed_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         op_q  <= OP_ADD;
      end else begin
         state <= state_nx;
         if (state == S_DECODE)
            op_q <= ctrl.opcode;
      end
   end

`ifdef MC_CTRL_MEM_TIMEOUT_EN
   logic stall, clear;
   assign stall = is_mem_req(state) && !ctrl.mem_ready && !timed_out;
   // A timeout from FETCH1 returns to FETCH1, so it must clear explicitly.
   assign clear = (state_nx != state) || timed_out;

   mc_ctrl_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .clear     (clear),
      .timed_out (timed_out),
      .fault     (ctrl.mem_fault)
   );
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      state_nx       = state;
      ctrl.mem_read  = 1'b0;
      ctrl.mem_write = 1'b0;
      ctrl.addr_src  = ADDR_SRC_PC;
      ctrl.ir1_write = 1'b0;
      ctrl.ir2_write = 1'b0;
      ctrl.mdr_write = 1'b0;
      ctrl.pc_write  = 1'b0;
      ctrl.pc_src    = PC_SRC_INC;
      ctrl.acc_write = 1'b0;
      ctrl.acc_src   = ACC_SRC_ALU;
      ctrl.alu_op    = ALU_ADD;

      // Gating on rst keeps a reset cycle from emitting half a write.
      if (!rst) begin
         case (state)
            S_IDLE: state_nx = S_FETCH1;
            S_FETCH1, S_FETCH2: begin
               ctrl.mem_read = 1'b1;
               if (ctrl.mem_ready) begin
                  ctrl.ir1_write = (state == S_FETCH1);
                  ctrl.ir2_write = (state == S_FETCH2);
                  ctrl.pc_write  = 1'b1;
                  state_nx       = (state == S_FETCH1) ? S_FETCH2 : S_DECODE;
               end
            end
            S_DECODE: begin
               case (ctrl.opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_LDA: state_nx = S_MEM_RD;
                  OP_NOT:  state_nx = S_EXEC_NOT;
                  OP_STA:  state_nx = S_MEM_WR;
                  OP_JMP:  state_nx = S_JUMP;
                  default: state_nx = ctrl.acc_zero ? S_JUMP : S_FETCH1;  // JZ
               endcase
            end
            S_MEM_RD: begin
               ctrl.mem_read = 1'b1;
               ctrl.addr_src = ADDR_SRC_IR;
               if (ctrl.mem_ready) begin
                  if (op_q == OP_LDA) begin
                     ctrl.acc_write = 1'b1;
                     ctrl.acc_src   = ACC_SRC_MEM;
                     state_nx       = S_FETCH1;
                  end else begin
                     ctrl.mdr_write = 1'b1;
                     state_nx       = S_EXEC_ALU;
                  end
               end
            end
            S_EXEC_ALU: begin
               ctrl.acc_write = 1'b1;
               case (op_q)
                  OP_SUB:  ctrl.alu_op = ALU_SUB;
                  OP_AND:  ctrl.alu_op = ALU_AND;
                  default: ctrl.alu_op = ALU_ADD;
               endcase
               state_nx = S_FETCH1;
            end
            S_EXEC_NOT: begin
               ctrl.acc_write = 1'b1;
               ctrl.alu_op    = ALU_NOT;
               state_nx       = S_FETCH1;
            end
            S_MEM_WR: begin
               ctrl.mem_write = 1'b1;
               ctrl.addr_src  = ADDR_SRC_IR;
               if (ctrl.mem_ready)
                  state_nx = S_FETCH1;
            end
            S_JUMP: begin
               ctrl.pc_write = 1'b1;
               ctrl.pc_src   = PC_SRC_IR;
               state_nx      = S_FETCH1;
            end
            default: state_nx = S_IDLE;
         endcase

         // Abandon a stuck request: nothing is driven and fetch restarts.
         if (timed_out) begin
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.addr_src  = ADDR_SRC_PC;
            ctrl.ir1_write = 1'b0;
            ctrl.ir2_write = 1'b0;
            ctrl.mdr_write = 1'b0;
            ctrl.pc_write  = 1'b0;
            ctrl.pc_src    = PC_SRC_INC;
            ctrl.acc_write = 1'b0;
            ctrl.acc_src   = ACC_SRC_ALU;
            ctrl.alu_op    = ALU_ADD;
            state_nx       = S_FETCH1;
         end
      end
   end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control FSM that sequences the accumulator datapath: two-byte instruction fetch, decode, operand read, ALU/load writeback, store and branch.
- Drives PC, IR, MDR and accumulator write strobes and the mux selects.
- Handshakes with a variable-latency byte memory via mem_ready.
- Sits between the instruction register and the datapath in the multi-cycle CPU top.

Parameters:
TIMEOUT_CYCLES, 16, maximum wait cycles on mem_ready before fault; used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  3  IR[15:13], stable from DECODE onward
acc_zero  in  1  accumulator == 0
mem_ready  in  1  memory completes current read/write this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
addr_src  out  1  0 = PC, 1 = IR[12:0] operand address
ir1_write  out  1  load IR high byte
ir2_write  out  1  load IR low byte
mdr_write  out  1  load memory data register
pc_write  out  1  PC load strobe
pc_src  out  1  0 = PC+1, 1 = IR[12:0]
acc_write  out  1  accumulator write enable
acc_src  out  1  0 = ALU result, 1 = memory data
alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- On rst: state = IDLE; all outputs 0.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 LDA, 101 STA, 110 JMP, 111 JZ.
- Strobes are decoded from state and mem_ready (Mealy on mem_ready only). Selects not listed for a state are 0.

States and transitions:
- IDLE: no strobes -> FETCH1.
- FETCH1: mem_read=1, addr_src=0.
  - mem_ready=1: ir1_write=1, pc_write=1 (pc_src=0), -> FETCH2.
  - mem_ready=0: hold state, no write strobes.
- FETCH2: same as FETCH1, but ir2_write=1 instead of ir1_write, -> DECODE.
- DECODE: no strobes; opcode and acc_zero sampled here only.
  - NOT -> EXEC_NOT.
  - ADD/SUB/AND/LDA -> MEM_RD.
  - STA -> MEM_WR.
  - JMP -> JUMP.
  - JZ -> JUMP if acc_zero=1, else FETCH1.
- MEM_RD: mem_read=1, addr_src=1. On mem_ready:
  - LDA: acc_write=1, acc_src=1, -> FETCH1.
  - Otherwise: mdr_write=1 -> EXEC_ALU.
- EXEC_ALU: acc_write=1, acc_src=0, alu_op = opcode[1:0] -> FETCH1.
- EXEC_NOT: acc_write=1, alu_op=11 -> FETCH1.
- MEM_WR: mem_write=1, addr_src=1; mem_ready -> FETCH1.
- JUMP: pc_write=1, pc_src=1 -> FETCH1.

Timing and boundary rules:
- Zero-wait cycle counts: ADD/SUB/AND 5, LDA 4, STA 4, NOT 4, JMP 4, JZ taken 4, JZ not taken 3.
- mem_read and mem_write are never asserted together.
- A request is held, with stable address select, until mem_ready is sampled high.
- mem_ready is ignored in states with no request.
- rst mid-instruction (any state, including during a wait): next state IDLE, outputs 0 the following cycle. No partial write strobe is issued in the reset cycle.
- PC wrap from 0x1FFF to 0 is the datapath's concern; the controller is unaffected.

Optional Feature:
- Macro MC_CTRL_MEM_TIMEOUT_EN.
- Defined:
  - Adds output mem_fault (1 bit).
  - A wait counter clears on every state change and increments each cycle a request is pending with mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES: request dropped, no write strobes, -> FETCH1, mem_fault set sticky until rst.
- Undefined: no counter, no port; waits are unbounded.

Decomposition:
- Package mc_cpu_pkg holds:
  - state enum;
  - opcode constants;
  - alu_op, pc_src, acc_src and addr_src encodings.
- Optional sub-module mc_ctrl_timeout: wait counter plus sticky fault, instantiated only under the macro.
- Everything else stays in one module.

Test Plan:
- rst held 2 cycles, then released; mem_ready=1 always -> all outputs 0 during reset; IDLE then FETCH1 with mem_read=1, addr_src=0.
- ADD fetch, zero-wait -> ir1_write then ir2_write with pc_write each; DECODE; MEM_RD with mdr_write; EXEC_ALU with acc_write=1, alu_op=00; total 5 cycles.
- LDA with mem_ready delayed 3 cycles in MEM_RD -> mem_read and addr_src=1 held 4 cycles; acc_write=1, acc_src=1 only on the ready cycle.
- JZ: acc_zero=0 -> FETCH1 after DECODE with no pc_write; acc_zero=1 -> JUMP with pc_write=1, pc_src=1.
- STA, with rst asserted while mem_write is pending and mem_ready=0 -> next cycle IDLE, mem_write=0, no further strobes.
- With MC_CTRL_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready stuck at 0 in FETCH1 -> after 4 wait cycles mem_fault=1 (stays 1), FSM returns to FETCH1.
